// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: 640x480@60 Hz raster constants and the coordinate type shared by the display pipeline.
package vga_timing_pkg;

    typedef logic [9:0] coord_t;

    localparam coord_t H_VISIBLE = 10'd640;
    localparam coord_t H_FP      = 10'd16;
    localparam coord_t H_SYNC    = 10'd96;
    localparam coord_t H_BP      = 10'd48;
    localparam coord_t H_TOTAL   = H_VISIBLE + H_FP + H_SYNC + H_BP;

    localparam coord_t V_VISIBLE = 10'd480;
    localparam coord_t V_FP      = 10'd10;
    localparam coord_t V_SYNC    = 10'd2;
    localparam coord_t V_BP      = 10'd33;
    localparam coord_t V_TOTAL   = V_VISIBLE + V_FP + V_SYNC + V_BP;

    // Sync windows are inclusive on both ends.
    localparam coord_t H_SYNC_START = H_VISIBLE + H_FP;
    localparam coord_t H_SYNC_END   = H_SYNC_START + H_SYNC - 10'd1;
    localparam coord_t V_SYNC_START = V_VISIBLE + V_FP;
    localparam coord_t V_SYNC_END   = V_SYNC_START + V_SYNC - 10'd1;

    localparam coord_t H_LAST = H_TOTAL - 10'd1;
    localparam coord_t V_LAST = V_TOTAL - 10'd1;

    function automatic logic in_window(coord_t v, coord_t lo, coord_t hi);
        return (v >= lo) && (v <= hi);
    endfunction

endpackage

// File: rtl/pixel_tick_divider.sv
// pixel_tick_divider: divides the system clock down to the pixel rate.
// tick is high during the last clk of each CLK_DIV-long period, marking the advance edge.
module pixel_tick_divider #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int W = $clog2(CLK_DIV);
    localparam logic [W-1:0] DIV_LAST = W'(CLK_DIV - 1);

    logic [W-1:0] r_div;

    assign tick = (r_div == DIV_LAST);

    always_ff @(posedge clk) begin
        if (reset)
            r_div <= '0;
        else
            r_div <= tick ? '0 : r_div + 1'b1;
    end

endmodule

// File: rtl/vga_scan_generator.sv
// vga_scan_generator: 640x480@60 Hz raster counters, sync/blank decode and line/frame markers.
// Every output is registered from the next-state coordinates, so all of them change on the same edge.
module vga_scan_generator
    import vga_timing_pkg::*;
#(
    parameter int   CLK_DIV  = 4,
    parameter logic SYNC_POL = 1'b0
) (
    input  logic   clk,
    input  logic   reset,
    output coord_t x,
    output coord_t y,
    output logic   hsync,
    output logic   vsync,
    output logic   video_on,
    output logic   pixel_tick,
    output logic   line_start,
    output logic   frame_start
);

    logic   w_adv;
    coord_t w_x_nxt;
    coord_t w_y_nxt;
    coord_t r_x;
    coord_t r_y;
    logic   r_hsync;
    logic   r_vsync;
    logic   r_video_on;
    logic   r_tick;
    logic   r_line;
    logic   r_frame;

    pixel_tick_divider #(.CLK_DIV(CLK_DIV)) u_div (
        .clk  (clk),
        .reset(reset),
        .tick (w_adv)
    );

    // Wrap by explicit compare; codes at or above the totals never occur.
    always_comb begin
        w_x_nxt = (r_x == H_LAST) ? '0 : r_x + 10'd1;
        w_y_nxt = (r_x != H_LAST) ? r_y : (r_y == V_LAST) ? '0 : r_y + 10'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_x        <= '0;
            r_y        <= '0;
            r_hsync    <= ~SYNC_POL;
            r_vsync    <= ~SYNC_POL;
            r_video_on <= 1'b0;
            r_tick     <= 1'b0;
            r_line     <= 1'b0;
            r_frame    <= 1'b0;
        end else begin
            r_tick  <= w_adv;
            r_line  <= w_adv && (w_x_nxt == '0);
            r_frame <= w_adv && (w_x_nxt == '0) && (w_y_nxt == '0);
            if (w_adv) begin
                r_x        <= w_x_nxt;
                r_y        <= w_y_nxt;
                r_hsync    <= in_window(w_x_nxt, H_SYNC_START, H_SYNC_END) ? SYNC_POL : ~SYNC_POL;
                r_vsync    <= in_window(w_y_nxt, V_SYNC_START, V_SYNC_END) ? SYNC_POL : ~SYNC_POL;
                r_video_on <= (w_x_nxt < H_VISIBLE) && (w_y_nxt < V_VISIBLE);
            end
        end
    end

    assign x           = r_x;
    assign y           = r_y;
    assign hsync       = r_hsync;
    assign vsync       = r_vsync;
    assign video_on    = r_video_on;
    assign pixel_tick  = r_tick;
    assign line_start  = r_line;
    assign frame_start = r_frame;

endmodule

// File: tb/tb_vga_scan_generator.sv
// tb_vga_scan_generator: scoreboard bench; a linear pixel-index model predicts each tick's outputs.
module tb_vga_scan_generator;
    import vga_timing_pkg::*;

    localparam int CLK_DIV = 4;
    localparam int FRAME   = 800 * 525;

    logic   clk   = 1'b0;
    logic   reset = 1'b1;
    coord_t x;
    coord_t y;
    logic   hsync;
    logic   vsync;
    logic   video_on;
    logic   pixel_tick;
    logic   line_start;
    logic   frame_start;

    vga_scan_generator #(.CLK_DIV(CLK_DIV), .SYNC_POL(1'b0)) dut (
        .clk        (clk),
        .reset      (reset),
        .x          (x),
        .y          (y),
        .hsync      (hsync),
        .vsync      (vsync),
        .video_on   (video_on),
        .pixel_tick (pixel_tick),
        .line_start (line_start),
        .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    typedef struct {
        int x;
        int y;
        bit hs;
        bit vs;
        bit vo;
        bit ls;
        bit fs;
    } exp_t;

    exp_t   q[$];
    exp_t   m_e;
    int     n_checks   = 0;
    int     n_fail     = 0;
    int     m_n        = 0;
    int     m_k        = 0;
    bit     m_in_reset = 1'b1;
    coord_t f_x;
    coord_t f_y;

    task automatic chk(string name, int got, int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Position n counts pixels from the start of a frame; everything else follows from it.
    function automatic exp_t expect_at(int n);
        exp_t e;
        e.x  = n % 800;
        e.y  = n / 800;
        e.hs = !(e.x >= 656 && e.x <= 751);
        e.vs = !(e.y >= 490 && e.y <= 491);
        e.vo = (e.x < 640) && (e.y < 480);
        e.ls = (e.x == 0);
        e.fs = (n == 0);
        return e;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_n = 0;
            m_k = 0;
            m_in_reset = 1'b1;
            q.delete();
        end else begin
            m_in_reset = 1'b0;
            m_k++;
            if (m_k % CLK_DIV == 0) begin
                m_n = (m_n + 1) % FRAME;
                q.push_back(expect_at(m_n));
            end
        end
    end

    always @(negedge clk) begin
        if (m_in_reset) begin
            chk("reset x", x, 0);
            chk("reset y", y, 0);
            chk("reset hsync", hsync, 1);
            chk("reset vsync", vsync, 1);
            chk("reset video_on", video_on, 0);
            chk("reset pixel_tick", pixel_tick, 0);
            chk("reset line_start", line_start, 0);
            chk("reset frame_start", frame_start, 0);
        end else if (pixel_tick) begin
            if (q.size() == 0) begin
                chk("spurious pixel_tick", 1, 0);
            end else begin
                m_e = q.pop_front();
                chk("x", x, m_e.x);
                chk("y", y, m_e.y);
                chk("hsync", hsync, m_e.hs);
                chk("vsync", vsync, m_e.vs);
                chk("video_on", video_on, m_e.vo);
                chk("line_start", line_start, m_e.ls);
                chk("frame_start", frame_start, m_e.fs);
            end
        end else begin
            chk("missed pixel_tick", q.size(), 0);
            chk("line_start off-tick", line_start, 0);
            chk("frame_start off-tick", frame_start, 0);
        end
    end

    // Places the raster at (jx,jy) between advances; the next tick continues from there.
    task automatic jump(int jx, int jy);
        @(negedge clk);
        #1;
        f_x = 10'(jx);
        f_y = 10'(jy);
        force dut.r_x = f_x;
        force dut.r_y = f_y;
        m_n = jy * 800 + jx;
        #1;
        release dut.r_x;
        release dut.r_y;
    endtask

    task automatic wait_tick(output int clks);
        clks = 0;
        for (int i = 0; i < 2 * CLK_DIV; i++) begin
            @(negedge clk);
            clks++;
            if (pixel_tick) return;
        end
        chk("pixel_tick timeout", 0, 1);
    endtask

    initial begin
        int c;
        int low;
        repeat (5) @(negedge clk);
        reset = 1'b0;
        wait_tick(c);
        chk("first tick latency", c, CLK_DIV);
        chk("first tick x", x, 1);
        chk("first tick video_on", video_on, 1);
        repeat (100) @(negedge clk);

        jump(799, 10);
        wait_tick(c);
        chk("line wrap x", x, 0);
        chk("line wrap y", y, 11);
        chk("line wrap line_start", line_start, 1);
        chk("line wrap frame_start", frame_start, 0);
        low = 0;
        for (int i = 0; i < 800; i++) begin
            wait_tick(c);
            if (!hsync) low++;
        end
        chk("hsync low ticks per line", low, 96);

        jump(799, 524);
        wait_tick(c);
        chk("frame wrap x", x, 0);
        chk("frame wrap y", y, 0);
        chk("frame wrap line_start", line_start, 1);
        chk("frame wrap frame_start", frame_start, 1);
        chk("frame wrap video_on", video_on, 1);

        jump(799, 488);
        low = 0;
        for (int i = 0; i < 4 * 800; i++) begin
            wait_tick(c);
            if (!vsync) low++;
        end
        chk("vsync low ticks", low, 2 * 800);

        jump(638, 0);
        wait_tick(c);
        chk("blank (639,0)", video_on, 1);
        wait_tick(c);
        chk("blank (640,0)", video_on, 0);
        jump(799, 478);
        wait_tick(c);
        chk("blank (0,479)", video_on, 1);
        jump(799, 479);
        wait_tick(c);
        chk("blank (0,480)", video_on, 0);

        jump(399, 300);
        wait_tick(c);
        chk("pre-reset x", x, 400);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        wait_tick(c);
        chk("post-reset tick latency", c, CLK_DIV);
        chk("post-reset x", x, 1);

        for (int i = 0; i < 8; i++) begin
            jump($urandom_range(0, 799), $urandom_range(0, 524));
            repeat ($urandom_range(20, 400)) @(negedge clk);
            if ($urandom_range(0, 3) == 0) begin
                reset = 1'b1;
                repeat ($urandom_range(1, 3)) @(negedge clk);
                reset = 1'b0;
                repeat ($urandom_range(5, 40)) @(negedge clk);
            end
        end

        repeat (10) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
